// File: rtl/eim_segment_pkg.sv
// Shared definitions for the EIM segment multiplexer: bus data width, default unmapped
// read word and the layout of the read-pipeline tag {valid, unmapped, seg_index}.
package eim_segment_pkg;

  localparam int          EIM_DATA_W        = 32;
  localparam logic [31:0] EIM_UNMAPPED_WORD = 32'hDEADCAFE;
  localparam int          TAG_VALID_W       = 1;
  localparam int          TAG_UNMAPPED_W    = 1;

  function automatic int tag_width(input int seg_bits);
    return TAG_VALID_W + TAG_UNMAPPED_W + seg_bits;
  endfunction

endpackage

// File: rtl/eim_segment_rdpipe.sv
// Read-tag shift register for eim_segment_mux: DEPTH stages, every stage cleared to
// all-invalid on reset so no read in flight can return afterwards.
module eim_segment_rdpipe #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] i_tag,
  output logic [TAG_W-1:0] o_tag
);

  logic [TAG_W-1:0] r_stage [DEPTH];

  // NOTE: this is a short tag pipeline, not a RAM, so every stage is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/eim_segment_mux.sv
// EIM sys-side bus to NUM_SEG core segments: registered request decode plus a
// READ_LATENCY-tracked read return. Define EIM_SEGMENT_STATS_EN to add err_count.
module eim_segment_mux
  import eim_segment_pkg::*;
#(
  parameter int          ADDR_W        = 17,
  parameter int          SEG_BITS      = 3,
  parameter int          NUM_SEG       = 6,
  parameter int          READ_LATENCY  = 1,
  parameter logic [31:0] UNMAPPED_WORD = EIM_UNMAPPED_WORD
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [ADDR_W-1:0]             sys_eim_addr,
  input  logic                          sys_eim_wr,
  input  logic                          sys_eim_rd,
  input  logic [EIM_DATA_W-1:0]         sys_write_data,
  output logic [EIM_DATA_W-1:0]         sys_read_data,
  output logic                          sys_read_valid,
  output logic [NUM_SEG-1:0]            seg_cs,
  output logic                          seg_we,
  output logic [ADDR_W-SEG_BITS-1:0]    seg_addr,
  output logic [EIM_DATA_W-1:0]         seg_write_data,
  input  logic [NUM_SEG*EIM_DATA_W-1:0] seg_read_data
`ifdef EIM_SEGMENT_STATS_EN
  ,
  output logic [15:0]                   err_count
`endif
);

  localparam int CORE_ADDR_W = ADDR_W - SEG_BITS;
  localparam int TAG_W       = tag_width(SEG_BITS);

  logic [SEG_BITS-1:0]    w_index;
  logic                   w_mapped;
  logic                   w_strobe;
  logic                   w_map_acc;
  logic                   w_push_rd;
  logic [NUM_SEG-1:0]     w_cs;
  logic [TAG_W-1:0]       w_tag_in;
  logic [TAG_W-1:0]       w_tag_out;
  logic                   w_tail_valid;
  logic                   w_tail_unmapped;
  logic [SEG_BITS-1:0]    w_tail_index;
  logic [EIM_DATA_W-1:0]  w_seg_word;

  logic [NUM_SEG-1:0]     r_seg_cs;
  logic                   r_seg_we;
  logic [CORE_ADDR_W-1:0] r_seg_addr;
  logic [EIM_DATA_W-1:0]  r_seg_wdata;
  logic [EIM_DATA_W-1:0]  r_read_data;
  logic                   r_read_valid;

  assign w_index   = sys_eim_addr[ADDR_W-1 -: SEG_BITS];
  assign w_mapped  = {1'b0, w_index} < (SEG_BITS+1)'(NUM_SEG);
  assign w_strobe  = sys_eim_wr | sys_eim_rd;
  assign w_map_acc = w_strobe & w_mapped;
  // A write wins a wr/rd collision, so a read only enters the pipeline when alone.
  assign w_push_rd = sys_eim_rd & ~sys_eim_wr;
  assign w_tag_in  = {w_push_rd, ~w_mapped, w_index};

  always_comb begin
    w_cs = '0;
    for (int i = 0; i < NUM_SEG; i++) w_cs[i] = w_map_acc && (w_index == SEG_BITS'(i));
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_seg_cs    <= '0;
      r_seg_we    <= 1'b0;
      r_seg_addr  <= '0;
      r_seg_wdata <= '0;
    end else begin
      r_seg_cs <= w_cs;
      r_seg_we <= sys_eim_wr & w_mapped;
      if (w_map_acc) r_seg_addr <= sys_eim_addr[CORE_ADDR_W-1:0];
      if (sys_eim_wr && w_mapped) r_seg_wdata <= sys_write_data;
    end
  end

  eim_segment_rdpipe #(
    .DEPTH (READ_LATENCY + 1),
    .TAG_W (TAG_W)
  ) u_rdpipe (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign {w_tail_valid, w_tail_unmapped, w_tail_index} = w_tag_out;

  // NOTE: default assignment first, otherwise the partial if-chain infers a latch.
  always_comb begin
    w_seg_word = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (w_tail_index == SEG_BITS'(i)) w_seg_word = seg_read_data[i*EIM_DATA_W +: EIM_DATA_W];
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_read_valid <= 1'b0;
      r_read_data  <= '0;
    end else begin
      r_read_valid <= w_tail_valid;
      if (w_tail_valid) r_read_data <= w_tail_unmapped ? UNMAPPED_WORD : w_seg_word;
    end
  end

`ifdef EIM_SEGMENT_STATS_EN
  logic        w_err_evt;
  logic [15:0] r_err_count;

  assign w_err_evt = (sys_eim_wr & sys_eim_rd) | (w_strobe & ~w_mapped);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_err_count <= '0;
    else if (w_err_evt && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
  end

  assign err_count = r_err_count;
`endif

  assign seg_cs         = r_seg_cs;
  assign seg_we         = r_seg_we;
  assign seg_addr       = r_seg_addr;
  assign seg_write_data = r_seg_wdata;
  assign sys_read_data  = r_read_data;
  assign sys_read_valid = r_read_valid;

endmodule

// File: tb/tb_eim_segment_mux.sv
// Self-checking bench for eim_segment_mux: directed cases plus random traffic checked
// against a cycle-indexed reference model. err_count checks need EIM_SEGMENT_STATS_EN.
module tb_eim_segment_mux;

  localparam int ADDR_W   = 17;
  localparam int SEG_BITS = 3;
  localparam int NUM_SEG  = 6;
  localparam int RL       = 1;
  localparam int CW       = ADDR_W - SEG_BITS;

  logic                    sys_clk = 1'b0;
  logic                    sys_rst = 1'b1;
  logic [ADDR_W-1:0]       sys_eim_addr = '0;
  logic                    sys_eim_wr = 1'b0;
  logic                    sys_eim_rd = 1'b0;
  logic [31:0]             sys_write_data = '0;
  logic [31:0]             sys_read_data;
  logic                    sys_read_valid;
  logic [NUM_SEG-1:0]      seg_cs;
  logic                    seg_we;
  logic [CW-1:0]           seg_addr;
  logic [31:0]             seg_write_data;
  logic [NUM_SEG*32-1:0]   seg_read_data = '0;
`ifdef EIM_SEGMENT_STATS_EN
  logic [15:0]             err_count;
`endif

  always #5 sys_clk = ~sys_clk;

  eim_segment_mux #(
    .ADDR_W       (ADDR_W),
    .SEG_BITS     (SEG_BITS),
    .NUM_SEG      (NUM_SEG),
    .READ_LATENCY (RL)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .sys_eim_addr   (sys_eim_addr),
    .sys_eim_wr     (sys_eim_wr),
    .sys_eim_rd     (sys_eim_rd),
    .sys_write_data (sys_write_data),
    .sys_read_data  (sys_read_data),
    .sys_read_valid (sys_read_valid),
    .seg_cs         (seg_cs),
    .seg_we         (seg_we),
    .seg_addr       (seg_addr),
    .seg_write_data (seg_write_data),
    .seg_read_data  (seg_read_data)
`ifdef EIM_SEGMENT_STATS_EN
    ,
    .err_count      (err_count)
`endif
  );

  typedef struct {
    int due;
    bit unmapped;
    int seg;
  } rd_t;

  int                    n_vec = 0;
  int                    n_err = 0;
  int                    cyc   = 0;
  rd_t                   pend [$];
  logic [NUM_SEG*32-1:0] seg_hist [int];
  logic [NUM_SEG-1:0]    cur_cs = '0;
  logic                  cur_we = 1'b0;
  logic [CW-1:0]         cur_addr = '0;
  logic [31:0]           cur_wdata = '0;
  logic [31:0]           last_data = '0;
  int                    m_err = 0;
  bit                    fixed_en = 1'b0;
  int                    fixed_seg = 0;
  logic [31:0]           fixed_word = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cs"}, 64'(seg_cs), 64'd0);
    check({tag, "_we"}, 64'(seg_we), 64'd0);
    check({tag, "_addr"}, 64'(seg_addr), 64'd0);
    check({tag, "_wdata"}, 64'(seg_write_data), 64'd0);
    check({tag, "_rvalid"}, 64'(sys_read_valid), 64'd0);
    check({tag, "_rdata"}, 64'(sys_read_data), 64'd0);
`ifdef EIM_SEGMENT_STATS_EN
    check({tag, "_err"}, 64'(err_count), 64'd0);
`endif
  endtask

  // One bus cycle: check the outputs expected now, then drive and model this cycle's request.
  task automatic step(input logic wr, input logic rd, input logic [ADDR_W-1:0] addr,
                      input logic [31:0] wd);
    int                    idx;
    bit                    mapped;
    logic                  exp_valid;
    logic [NUM_SEG*32-1:0] row;
    rd_t                   p;
    @(negedge sys_clk);
    exp_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      p         = pend.pop_front();
      row       = seg_hist[cyc-1];
      last_data = p.unmapped ? 32'hDEADCAFE : row[p.seg*32 +: 32];
      exp_valid = 1'b1;
    end
    check("seg_cs", 64'(seg_cs), 64'(cur_cs));
    check("seg_we", 64'(seg_we), 64'(cur_we));
    check("seg_addr", 64'(seg_addr), 64'(cur_addr));
    check("seg_wdata", 64'(seg_write_data), 64'(cur_wdata));
    check("read_valid", 64'(sys_read_valid), 64'(exp_valid));
    check("read_data", 64'(sys_read_data), 64'(last_data));
`ifdef EIM_SEGMENT_STATS_EN
    check("err_count", 64'(err_count), 64'(m_err));
`endif
    sys_eim_wr     = wr;
    sys_eim_rd     = rd;
    sys_eim_addr   = addr;
    sys_write_data = wd;
    for (int i = 0; i < NUM_SEG; i++) seg_read_data[i*32 +: 32] = $urandom;
    if (fixed_en) seg_read_data[fixed_seg*32 +: 32] = fixed_word;
    seg_hist[cyc] = seg_read_data;
    if (seg_hist.exists(cyc - 16)) seg_hist.delete(cyc - 16);

    idx    = int'(addr[ADDR_W-1 -: SEG_BITS]);
    mapped = idx < NUM_SEG;
    cur_cs = (mapped && (wr || rd)) ? NUM_SEG'(1 << idx) : '0;
    cur_we = wr && mapped;
    if (mapped && (wr || rd)) cur_addr = addr[CW-1:0];
    if (mapped && wr) cur_wdata = wd;
    if (rd && !wr) pend.push_back('{cyc + 2 + RL, !mapped, idx});
    if (((wr && rd) || ((wr || rd) && !mapped)) && m_err < 65535) m_err++;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, sys_eim_addr, sys_write_data);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    #1;
    sys_rst    = 1'b1;
    sys_eim_wr = 1'b0;
    sys_eim_rd = 1'b0;
    #1;
    check_all_zero("rst_mid");
    pend.delete();
    cur_cs = '0; cur_we = 1'b0; cur_addr = '0; cur_wdata = '0;
    last_data = '0; m_err = 0;
    repeat (2) begin
      @(negedge sys_clk);
      check("rst_hold_valid", 64'(sys_read_valid), 64'd0);
    end
    sys_rst = 1'b0;
    cyc += 3;
  endtask

  int                unsigned sel;
  logic [ADDR_W-1:0] raddr;
  int                pulses;

  initial begin
    repeat (3) @(negedge sys_clk);
    check_all_zero("rst_init");
    sys_rst = 1'b0;
    cyc     = 1;

    // Write to segment 1.
    step(1'b1, 1'b0, 17'h04010, 32'h12345678);
    idle(1);
    check("t2_cs", 64'(seg_cs), 64'(6'b000010));
    check("t2_we", 64'(seg_we), 64'd1);
    check("t2_addr", 64'(seg_addr), 64'h0010);
    check("t2_wdata", 64'(seg_write_data), 64'h12345678);

    // Read from segment 2 with a known word.
    fixed_en = 1'b1; fixed_seg = 2; fixed_word = 32'hA5A5A5A5;
    step(1'b0, 1'b1, 17'h08000, 32'h0);
    idle(3);
    check("t3_valid", 64'(sys_read_valid), 64'd1);
    check("t3_data", 64'(sys_read_data), 64'hA5A5A5A5);
    fixed_en = 1'b0;

    // Back-to-back reads 0,1,0.
    step(1'b0, 1'b1, 17'h00123, 32'h0);
    step(1'b0, 1'b1, 17'h04456, 32'h0);
    step(1'b0, 1'b1, 17'h00789, 32'h0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      pulses += int'(sys_read_valid);
    end
    check("t4_pulses", 64'(pulses), 64'd3);

    // Unmapped read (index 7).
    step(1'b0, 1'b1, 17'h1C000, 32'h0);
    idle(1);
    check("t5_cs", 64'(seg_cs), 64'd0);
    idle(2);
    check("t5_data", 64'(sys_read_data), 64'hDEADCAFE);
`ifdef EIM_SEGMENT_STATS_EN
    check("t5_err", 64'(err_count), 64'd1);
`endif

    // Collision on segment 3.
    step(1'b1, 1'b1, 17'h0C0AA, 32'hCAFEF00D);
    idle(1);
    check("t6_cs", 64'(seg_cs), 64'(6'b001000));
    check("t6_we", 64'(seg_we), 64'd1);
    check("t6_wdata", 64'(seg_write_data), 64'hCAFEF00D);
    idle(3);

    // Reset with a read in flight.
    step(1'b0, 1'b1, 17'h10004, 32'h0);
    do_reset();
    idle(5);

    for (int k = 0; k < 500; k++) begin
      sel   = $urandom_range(0, 9);
      raddr = ADDR_W'($urandom);
      step(sel inside {[4:6], 9}, sel inside {[0:3], 9}, raddr, $urandom);
    end
    idle(6);

`ifdef EIM_SEGMENT_STATS_EN
    for (int k = 0; k < 65540; k++) step(1'b1, 1'b1, 17'h00001, 32'h1);
    idle(1);
    check("t6_err_sat", 64'(err_count), 64'hFFFF);
`endif

    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
